// File: rtl/sar_seq_pkg.sv
// ------------------------------------------------------------------
// sar_seq_pkg: shared channel state encoding and readout word packing
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package sar_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HOLD   = 3'd1,
    STROBE = 3'd2,
    DECIDE = 3'd3,
    DONE   = 3'd4,
    RESET  = 3'd5
  } chan_state_e;

  localparam int DEF_NUMCHANNELS = 64;
  localparam int CH_BITS         = $clog2(DEF_NUMCHANNELS);
  localparam int MAX_CH_BITS     = 8;
  localparam int MAX_ADCBITS     = 12;

  // Widest possible {channel, code}; callers truncate to their own width.
  function automatic logic [MAX_CH_BITS+MAX_ADCBITS-1:0] pack_word(
      input logic [MAX_CH_BITS-1:0] ch,
      input logic [MAX_ADCBITS-1:0] code,
      input int                     adcbits);
    return ({{MAX_ADCBITS{1'b0}}, ch} << adcbits) | {{MAX_CH_BITS{1'b0}}, code};
  endfunction

endpackage

`default_nettype wire

// File: rtl/sar_array_sequencer_if.sv
// ------------------------------------------------------------------
// sar_array_sequencer_if: valid/ready readout port of the sequencer
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface sar_array_sequencer_if #(
  parameter int DATA_W = 16
) ();
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              data_ready;

  modport master (output data_out, output data_valid, input data_ready);
  modport slave  (input data_out, input data_valid, output data_ready);
endinterface

`default_nettype wire

// File: rtl/sar_channel_fsm.sv
// ------------------------------------------------------------------
// sar_channel_fsm: hit synchronizer, trigger, SAR search and CSA reset
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module sar_channel_fsm
  import sar_seq_pkg::*;
#(
  parameter int ADCBITS      = 10,
  parameter int HOLD_CYCLES  = 2,
  parameter int RESET_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               hit,
  input  logic               comp,
  input  logic               ext_trig,
  input  logic               trig_mode,
  input  logic               mask,
  input  logic               gnt,
  output logic               sample,
  output logic               strobe,
  output logic               csa_reset,
  output logic               req,
  output logic               drop,
  output logic [ADCBITS-1:0] dac_word,
  output logic [ADCBITS-1:0] code
);

  localparam int CNT_MAX = (HOLD_CYCLES > RESET_CYCLES) ? HOLD_CYCLES : RESET_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BIT_W   = $clog2(ADCBITS);
  localparam logic [CNT_W-1:0]   HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]   RST_LAST  = CNT_W'(RESET_CYCLES - 1);
  localparam logic [BIT_W-1:0]   MSB_BIT   = BIT_W'(ADCBITS - 1);
  localparam logic [ADCBITS-1:0] MID_CODE  = {1'b1, {(ADCBITS-1){1'b0}}};

  chan_state_e        state_q, state_d;
  logic [2:0]         sync_q, sync_d;   // [1:0] synchronizer, [2] edge history
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [ADCBITS-1:0] code_q, code_d;
  logic [ADCBITS-1:0] dac_q, dac_d;
  logic               trig;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sync_q  <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
      code_q  <= '0;
      dac_q   <= '0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      code_q  <= code_d;
      dac_q   <= dac_d;
    end
  end

  always_comb begin
    sync_d  = {sync_q[1:0], hit};
    trig    = ~mask & (trig_mode ? ext_trig : (sync_q[1] & ~sync_q[2]));
    drop    = trig & (state_q != IDLE);
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    code_d  = code_q;
    dac_d   = dac_q;

    case (state_q)
      IDLE: begin
        if (trig) begin
          state_d = HOLD;
          cnt_d   = '0;
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = STROBE;
          code_d  = MID_CODE;
          bit_d   = MSB_BIT;
          dac_d   = MID_CODE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STROBE: state_d = DECIDE;
      DECIDE: begin
        if (!comp) code_d[bit_q] = 1'b0;
        if (bit_q != '0) begin
          bit_d         = bit_q - BIT_W'(1);
          code_d[bit_d] = 1'b1;
          dac_d         = code_d;
          state_d       = STROBE;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (gnt) begin
          state_d = RESET;
          cnt_d   = '0;
        end
      end
      RESET: begin
        if (cnt_q == RST_LAST) state_d = IDLE;
        else                   cnt_d   = cnt_q + CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  assign sample    = (state_q == IDLE) || (state_q == RESET);
  assign strobe    = (state_q == STROBE);
  assign csa_reset = (state_q == RESET);
  assign req       = (state_q == DONE);
  assign dac_word  = dac_q;
  assign code      = code_q;

endmodule

`default_nettype wire

// File: rtl/sar_array_sequencer.sv
// ------------------------------------------------------------------
// sar_array_sequencer: N-channel SAR sequencer with round-robin readout
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module sar_array_sequencer
  import sar_seq_pkg::*;
#(
  parameter int NUMCHANNELS  = 64,
  parameter int ADCBITS      = 10,
  parameter int HOLD_CYCLES  = 2,
  parameter int RESET_CYCLES = 4,
  parameter int DROP_BITS    = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUMCHANNELS-1:0]         hit,
  input  logic [NUMCHANNELS-1:0]         comp,
  input  logic                           ext_trig,
  input  logic                           trig_mode,
  input  logic [NUMCHANNELS-1:0]         channel_mask,
  output logic [NUMCHANNELS-1:0]         sample,
  output logic [NUMCHANNELS-1:0]         strobe,
  output logic [NUMCHANNELS*ADCBITS-1:0] dac_word,
  output logic [NUMCHANNELS-1:0]         csa_reset,
  sar_array_sequencer_if.master          rd,
  output logic [DROP_BITS-1:0]           dropped_count
);

  localparam int CH_W  = $clog2(NUMCHANNELS);
  localparam int DW    = CH_W + ADCBITS;
  localparam int SUM_W = DROP_BITS + 9;
  localparam logic [SUM_W-1:0] DROP_MAX = {9'd0, {DROP_BITS{1'b1}}};

  logic [NUMCHANNELS-1:0] req, gnt, drop;
  logic [ADCBITS-1:0]     codes [NUMCHANNELS];

  logic [DW-1:0]          data_q, data_d;
  logic                   valid_q, valid_d;
  logic [CH_W-1:0]        ptr_q, ptr_d;
  logic [DROP_BITS-1:0]   drop_cnt_q, drop_cnt_d;

  logic                   found, load_en;
  logic [CH_W-1:0]        winner, idx;
  logic [CH_W:0]          idx_sum;
  logic [SUM_W-1:0]       drop_sum;

  for (genvar i = 0; i < NUMCHANNELS; i++) begin : g_ch
    sar_channel_fsm #(
      .ADCBITS      (ADCBITS),
      .HOLD_CYCLES  (HOLD_CYCLES),
      .RESET_CYCLES (RESET_CYCLES)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .hit       (hit[i]),
      .comp      (comp[i]),
      .ext_trig  (ext_trig),
      .trig_mode (trig_mode),
      .mask      (channel_mask[i]),
      .gnt       (gnt[i]),
      .sample    (sample[i]),
      .strobe    (strobe[i]),
      .csa_reset (csa_reset[i]),
      .req       (req[i]),
      .drop      (drop[i]),
      .dac_word  (dac_word[ADCBITS*i +: ADCBITS]),
      .code      (codes[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q     <= '0;
      valid_q    <= 1'b0;
      ptr_q      <= '0;
      drop_cnt_q <= '0;
    end else begin
      data_q     <= data_d;
      valid_q    <= valid_d;
      ptr_q      <= ptr_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Round-robin search: first DONE channel at or after the pointer, wrapping.
  always_comb begin
    found   = 1'b0;
    winner  = '0;
    idx     = '0;
    idx_sum = '0;
    for (int k = 0; k < NUMCHANNELS; k++) begin
      idx_sum = {1'b0, ptr_q} + (CH_W+1)'(k);
      if (idx_sum >= (CH_W+1)'(NUMCHANNELS)) idx_sum = idx_sum - (CH_W+1)'(NUMCHANNELS);
      idx = idx_sum[CH_W-1:0];
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    load_en = found && (!valid_q || rd.data_ready);
    gnt     = '0;
    data_d  = data_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    if (load_en) begin
      gnt[winner] = 1'b1;
      valid_d     = 1'b1;
      data_d      = DW'(pack_word(MAX_CH_BITS'(winner), MAX_ADCBITS'(codes[winner]), ADCBITS));
      ptr_d       = (winner == CH_W'(NUMCHANNELS - 1)) ? '0 : winner + CH_W'(1);
    end else if (valid_q && rd.data_ready) begin
      valid_d = 1'b0;
    end
  end

  always_comb begin
    drop_sum   = {9'd0, drop_cnt_q} + SUM_W'($countones(drop));
    drop_cnt_d = (drop_sum > DROP_MAX) ? {DROP_BITS{1'b1}} : drop_sum[DROP_BITS-1:0];
  end

  assign rd.data_out    = data_q;
  assign rd.data_valid  = valid_q;
  assign dropped_count  = drop_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_sar_array_sequencer.sv
// ------------------------------------------------------------------
// tb_sar_array_sequencer: directed scoreboard bench for the sequencer
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_sar_array_sequencer;
  import sar_seq_pkg::*;

  localparam int NCH   = 64;
  localparam int ADCB  = 10;
  localparam int HOLD  = 2;
  localparam int RSTC  = 4;
  localparam int DROPB = 16;
  localparam int DW    = CH_BITS + ADCB;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NCH-1:0]       hit, comp, channel_mask, sample, strobe, csa_reset;
  logic                 ext_trig, trig_mode, ready;
  logic [NCH*ADCB-1:0]  dac_word;
  logic [DROPB-1:0]     dropped_count;
  int                   vin [NCH];

  sar_array_sequencer_if #(.DATA_W(DW)) rd_if ();
  assign rd_if.data_ready = ready;

  sar_array_sequencer #(
    .NUMCHANNELS  (NCH),
    .ADCBITS      (ADCB),
    .HOLD_CYCLES  (HOLD),
    .RESET_CYCLES (RSTC),
    .DROP_BITS    (DROPB)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .hit           (hit),
    .comp          (comp),
    .ext_trig      (ext_trig),
    .trig_mode     (trig_mode),
    .channel_mask  (channel_mask),
    .sample        (sample),
    .strobe        (strobe),
    .dac_word      (dac_word),
    .csa_reset     (csa_reset),
    .rd            (rd_if),
    .dropped_count (dropped_count)
  );

  always #5 clk = ~clk;

  // DAC trial level sits half an LSB below its code, so "input above DAC" is vin >= code.
  always_comb begin
    comp = '0;
    for (int i = 0; i < NCH; i++) comp[i] = (vin[i] >= int'(dac_word[ADCB*i +: ADCB]));
  end

  int            n_tests = 0;
  int            n_fail  = 0;
  int            strobe5 = 0, csa5 = 0, low5 = 0, valid_cycles = 0, n_words = 0;
  logic [DW-1:0] sb [$];
  logic [DW-1:0] exp_w;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h required=0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (strobe[5])     strobe5++;
    if (csa_reset[5])  csa5++;
    if (sample[5] === 1'b0) low5++;
    if (rd_if.data_valid === 1'b1) valid_cycles++;
    if (!reset && rd_if.data_valid && ready) begin
      n_words++;
      n_tests++;
      assert (sb.size() > 0) else begin
        n_fail++;
        $error("FAIL unexpected_word observed=0x%0h required=none", rd_if.data_out);
      end
      if (sb.size() > 0) begin
        exp_w = sb.pop_front();
        check("data_out", 64'(rd_if.data_out), 64'(exp_w));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) tick();
  endtask

  task automatic expect_word(input int ch, input int code);
    sb.push_back(DW'(ch * (2 ** ADCB) + code));
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int k = 0;
    while (sb.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    check(tag, 64'(sb.size()), 64'(0));
    cycles(RSTC + 4);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int k = 0;
    while (rd_if.data_valid !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    check(tag, 64'(rd_if.data_valid), 64'(1));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, run, changes, s5, c5, l5, w0, v0;
    logic [DW-1:0] frozen;

    reset = 1'b1; hit = '0; ext_trig = 1'b0; trig_mode = 1'b0; channel_mask = '0; ready = 1'b1;
    for (int i = 0; i < NCH; i++) vin[i] = 0;
    cycles(3);
    check("rst_sample",   64'(sample), {64{1'b1}});
    check("rst_strobe",   64'(strobe), 64'(0));
    check("rst_dac_zero", 64'(dac_word == '0), 64'(1));
    check("rst_csa",      64'(csa_reset), 64'(0));
    check("rst_valid",    64'(rd_if.data_valid), 64'(0));
    check("rst_drop",     64'(dropped_count), 64'(0));
    reset = 1'b0;
    tick();

    // T1: single conversion on ch5, latency and strobe/reset pulse counts
    vin[5] = 613;
    expect_word(5, 613);
    s5 = strobe5; c5 = csa5; l5 = low5;
    hit[5] = 1'b1;
    lat = 0;
    while (rd_if.data_valid !== 1'b1 && lat < 200) begin
      tick();
      lat++;
      if (lat == 3) hit = '0;
    end
    check("t1_latency", 64'(lat), 64'(2 + (1 + HOLD + 2*ADCB) + 1));
    wait_drain("t1_drain", 20);
    check("t1_strobes",   64'(strobe5 - s5), 64'(ADCB));
    check("t1_csa_cyc",   64'(csa5 - c5),    64'(RSTC));
    check("t1_hold_cyc",  64'(low5 - l5),    64'(1 + HOLD + 2*ADCB));

    // T2: code extremes on the array edges; pointer sits at 6 so ch63 wins first
    vin[0] = 0; vin[63] = 1023;
    expect_word(63, 1023);
    expect_word(0, 0);
    hit[0] = 1'b1; hit[63] = 1'b1;
    cycles(3);
    hit = '0;
    wait_drain("t2_drain", 100);

    // T3: all channels at once from pointer 0, then again from pointer 10
    do_reset();
    for (int i = 0; i < NCH; i++) vin[i] = (i * 97 + 5) % 1024;
    for (int i = 0; i < NCH; i++) expect_word(i, vin[i]);
    hit = '1;
    cycles(3);
    hit = '0;
    wait_valid("t3_valid", 100);
    run = 0;
    while (rd_if.data_valid === 1'b1 && run < 100) begin
      tick();
      run++;
    end
    check("t3_burst_len", 64'(run), 64'(NCH));
    wait_drain("t3_drain", 20);

    vin[9] = 300;
    expect_word(9, 300);
    hit[9] = 1'b1;
    cycles(3);
    hit = '0;
    wait_drain("t3_ch9_drain", 100);
    for (int k = 0; k < NCH; k++) expect_word((10 + k) % NCH, vin[(10 + k) % NCH]);
    hit = '1;
    cycles(3);
    hit = '0;
    wait_drain("t3_rr_drain", 200);

    // T4: consumer stalls with ch3 and ch7 both finished
    ready = 1'b0;
    vin[3] = 100; vin[7] = 900;
    expect_word(3, 100);
    expect_word(7, 900);
    w0 = n_words;
    hit[3] = 1'b1; hit[7] = 1'b1;
    cycles(3);
    hit = '0;
    wait_valid("t4_valid", 100);
    check("t4_first", 64'(rd_if.data_out), 64'(3 * 1024 + 100));
    frozen = rd_if.data_out;
    changes = 0;
    repeat (50) begin
      tick();
      if (rd_if.data_out !== frozen || rd_if.data_valid !== 1'b1) changes++;
    end
    check("t4_frozen",   64'(changes), 64'(0));
    check("t4_ch7_done", 64'({sample[7], csa_reset[7]}), 64'(0));
    check("t4_no_words", 64'(n_words - w0), 64'(0));
    ready = 1'b1;
    wait_drain("t4_drain", 20);
    check("t4_words", 64'(n_words - w0), 64'(2));

    // T5: retrigger while converting is dropped, then saturate the counter
    vin[2] = 450;
    expect_word(2, 450);
    w0 = n_words;
    hit[2] = 1'b1; cycles(3); hit[2] = 1'b0;
    cycles(5);
    hit[2] = 1'b1; cycles(3); hit[2] = 1'b0;
    wait_drain("t5_drain", 100);
    check("t5_drop_one", 64'(dropped_count), 64'(1));
    check("t5_one_word", 64'(n_words - w0), 64'(1));

    ready = 1'b0;
    trig_mode = 1'b1;
    ext_trig = 1'b1;
    cycles(1200);
    check("t5_saturate", 64'(dropped_count), 64'(16'hFFFF));
    cycles(20);
    check("t5_sat_hold", 64'(dropped_count), 64'(16'hFFFF));
    ext_trig = 1'b0;
    do_reset();
    check("t5_drop_clr", 64'(dropped_count), 64'(0));
    ready = 1'b1;

    // T6: external trigger with all but ch0/ch1 masked
    channel_mask = ~64'h3;
    vin[0] = 777; vin[1] = 42;
    expect_word(0, 777);
    expect_word(1, 42);
    w0 = n_words;
    ext_trig = 1'b1;
    tick();
    ext_trig = 1'b0;
    wait_drain("t6_drain", 100);
    check("t6_words",  64'(n_words - w0), 64'(2));
    check("t6_nodrop", 64'(dropped_count), 64'(0));

    // T6: reset during STROBE aborts with no output
    trig_mode = 1'b0;
    channel_mask = '0;
    vin[4] = 500;
    hit[4] = 1'b1; cycles(3); hit[4] = 1'b0;
    lat = 0;
    while (strobe[4] !== 1'b1 && lat < 50) begin
      tick();
      lat++;
    end
    check("t6_strobe_seen", 64'(strobe[4]), 64'(1));
    reset = 1'b1;
    tick();
    check("t6_rst_sample", 64'(sample), {64{1'b1}});
    check("t6_rst_strobe", 64'(strobe), 64'(0));
    check("t6_rst_dac",    64'(dac_word == '0), 64'(1));
    check("t6_rst_csa",    64'(csa_reset), 64'(0));
    check("t6_rst_valid",  64'(rd_if.data_valid), 64'(0));
    reset = 1'b0;
    v0 = valid_cycles;
    cycles(40);
    check("t6_no_output", 64'(valid_cycles - v0), 64'(0));
    check("t6_sb_empty",  64'(sb.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
